// File: rtl/matrix_result_requant.sv
// Captures nine tagged 3x3 accumulator results, requantizes each to DATA_WIDTH with saturation,
// and drains the frame row-major through a ready-gated write port. Build option: REQUANT_ROUND_EN.
module matrix_result_requant #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 66,
    parameter int FRAC_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ACC_WIDTH-1:0]  c_in,
    input  logic                  c_valid,
    input  logic [1:0]            row,
    input  logic [1:0]            col,
    input  logic                  mm_done,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [3:0]            out_addr,
    output logic                  out_wen,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  sat_flag,
    output logic                  overrun,
    output logic                  incomplete,
    output logic [1:0]            dbg_state
);

    // Handshake: an element transfers on every cycle where out_wen && out_ready; while
    // out_ready is low, out_addr/out_data hold and out_wen stays high until accepted.
    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_DRAIN   = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic signed [ACC_WIDTH:0] MAX_V =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] MIN_V =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    state_t                  r_state;
    logic [3:0]              r_idx;
    logic [8:0]              r_mask;
    logic                    r_mm_done_d;
    logic [DATA_WIDTH-1:0]   r_buf [0:8];
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_wen;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_sat;
    logic                    r_ovr;
    logic                    r_inc;

    logic signed [ACC_WIDTH:0] w_ext;
    logic signed [ACC_WIDTH:0] w_sum;
    logic signed [ACC_WIDTH:0] w_shift;
    logic                      w_sat_hi;
    logic                      w_sat_lo;
    logic [DATA_WIDTH-1:0]     w_q;
    logic                      w_tag_ok;
    logic                      w_wr_en;
    logic [3:0]                w_wr_idx;
    logic [8:0]                w_mask_next;
    logic                      w_edge;
    logic                      w_set_ovr;
    logic                      w_set_sat;
    logic                      w_set_inc;

    // One extra bit of headroom keeps the rounding add from wrapping.
    assign w_ext = $signed({c_in[ACC_WIDTH-1], c_in});
`ifdef REQUANT_ROUND_EN
    localparam logic signed [ACC_WIDTH:0] ROUND_ADD = {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_BITS - 1);
    assign w_sum = w_ext + ROUND_ADD;
`else
    assign w_sum = w_ext;
`endif
    assign w_shift  = w_sum >>> FRAC_BITS;
    assign w_sat_hi = (w_shift > MAX_V);
    assign w_sat_lo = (w_shift < MIN_V);

    always_comb begin
        w_q = w_shift[DATA_WIDTH-1:0];
        if (w_sat_hi) begin
            w_q = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (w_sat_lo) begin
            w_q = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    assign w_tag_ok    = (row != 2'd3) && (col != 2'd3);
    assign w_wr_en     = c_valid && w_tag_ok && (r_state == S_COLLECT);
    assign w_wr_idx    = ({2'b00, row} << 1) + {2'b00, row} + {2'b00, col};
    assign w_mask_next = r_mask | (w_wr_en ? (9'd1 << w_wr_idx) : 9'd0);
    assign w_edge      = mm_done && !r_mm_done_d;
    assign w_set_ovr   = c_valid && ((r_state != S_COLLECT) || !w_tag_ok);
    assign w_set_sat   = w_wr_en && (w_sat_hi || w_sat_lo);
    assign w_set_inc   = (r_state == S_COLLECT) && w_edge && (w_mask_next != 9'h1FF);

    // Frame storage carries no reset; uncaptured slots simply keep their previous contents.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_idx] <= w_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_COLLECT;
            r_idx       <= 4'd0;
            r_mask      <= 9'd0;
            r_mm_done_d <= 1'b0;
            r_out_data  <= '0;
            r_out_wen   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sat       <= 1'b0;
            r_ovr       <= 1'b0;
            r_inc       <= 1'b0;
        end else begin
            r_mm_done_d <= mm_done;

            if (w_set_sat)     r_sat <= 1'b1;
            else if (clr)      r_sat <= 1'b0;
            if (w_set_ovr)     r_ovr <= 1'b1;
            else if (clr)      r_ovr <= 1'b0;
            if (w_set_inc)     r_inc <= 1'b1;
            else if (clr)      r_inc <= 1'b0;

            case (r_state)
                S_COLLECT: begin
                    r_mask <= w_mask_next;
                    if (w_edge) begin
                        r_state   <= S_DRAIN;
                        r_idx     <= 4'd0;
                        r_out_wen <= 1'b1;
                        r_busy    <= 1'b1;
                        // Forward a same-cycle write to slot 0 so the first beat is current.
                        r_out_data <= (w_wr_en && (w_wr_idx == 4'd0)) ? w_q : r_buf[0];
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (r_idx == 4'd8) begin
                            r_state   <= S_DONE;
                            r_out_wen <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_idx      <= r_idx + 4'd1;
                            r_out_data <= r_buf[r_idx + 4'd1];
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_mask  <= 9'd0;
                    r_idx   <= 4'd0;
                    r_state <= S_COLLECT;
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

    assign out_data   = r_out_data;
    assign out_addr   = r_idx;
    assign out_wen    = r_out_wen;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sat_flag   = r_sat;
    assign overrun    = r_ovr;
    assign incomplete = r_inc;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_matrix_result_requant.sv
// Randomized bench for matrix_result_requant; expected frames come from an arithmetic model
// of requantization and a 9-entry buffer image. Honours REQUANT_ROUND_EN when defined.
module tb_matrix_result_requant;
    localparam int DW = 32;
    localparam int AW = 66;
    localparam int FB = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] c_in;
    logic          c_valid;
    logic [1:0]    row;
    logic [1:0]    col;
    logic          mm_done;
    logic          clr;
    logic [DW-1:0] out_data;
    logic [3:0]    out_addr;
    logic          out_wen;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          sat_flag;
    logic          overrun;
    logic          incomplete;
    logic [1:0]    dbg_state;

    matrix_result_requant #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .FRAC_BITS(FB)) dut (
        .clk(clk), .rst(rst), .c_in(c_in), .c_valid(c_valid), .row(row), .col(col),
        .mm_done(mm_done), .clr(clr), .out_data(out_data), .out_addr(out_addr),
        .out_wen(out_wen), .out_ready(out_ready), .busy(busy), .done(done),
        .sat_flag(sat_flag), .overrun(overrun), .incomplete(incomplete), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_buf[9];
    bit            model_mask[9];
    bit            exp_sat, exp_ovr, exp_inc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: value/2^F (floored), optional +0.5 before flooring, then clamp to DW signed.
    task automatic requant(input logic [AW-1:0] c, output logic [DW-1:0] q, output bit sat);
        logic signed [127:0] v, s, hi, lo;
        v = $signed(c);
`ifdef REQUANT_ROUND_EN
        v = v + (128'sd1 <<< (FB - 1));
`endif
        s  = v >>> FB;
        hi = (128'sd1 <<< (DW - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (DW - 1));
        sat = 1'b0;
        if (s > hi) begin
            s = hi; sat = 1'b1;
        end else if (s < lo) begin
            s = lo; sat = 1'b1;
        end
        q = s[DW-1:0];
    endtask

    task automatic model_capture(input int r, input int cc, input logic [AW-1:0] v);
        logic [DW-1:0] q;
        bit            s;
        if (r < 3 && cc < 3) begin
            requant(v, q, s);
            model_buf[r*3+cc]  = q;
            model_mask[r*3+cc] = 1'b1;
            if (s) exp_sat = 1'b1;
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    function automatic logic [AW-1:0] rnd_acc();
        logic [95:0]          r;
        logic signed [AW-1:0] v;
        r = {$urandom, $urandom, $urandom};
        v = $signed(r[AW-1:0]);
        v = v >>> $urandom_range(0, 40);
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input int r, input int cc, input logic [AW-1:0] v);
        c_valid = 1'b1; row = r[1:0]; col = cc[1:0]; c_in = v;
        @(posedge clk); #1;
        c_valid = 1'b0;
        model_capture(r, cc, v);
    endtask

    task automatic send_full_random();
        for (int k = 0; k < 9; k++) send(k / 3, k % 3, rnd_acc());
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        exp_sat = 0; exp_ovr = 0; exp_inc = 0;
    endtask

    task automatic start_drain(input bit with_elem, input int r, input int cc, input logic [AW-1:0] v);
        bit all;
        mm_done = 1'b1;
        if (with_elem) begin
            c_valid = 1'b1; row = r[1:0]; col = cc[1:0]; c_in = v;
        end
        @(posedge clk); #1;
        c_valid = 1'b0;
        if (with_elem) model_capture(r, cc, v);
        all = 1'b1;
        for (int i = 0; i < 9; i++) if (!model_mask[i]) all = 1'b0;
        if (!all) exp_inc = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(model_buf[i]);
            model_mask[i] = 1'b0;
        end
    endtask

    // mode 0: ready always high; 1: ready pattern 1,0,0; 2: random ready.
    task automatic drain(input int mode, input bit inject);
        int            i_exp = 0;
        int            cyc = 0;
        bit            rdy;
        bit            stalled = 0;
        logic [3:0]    p_addr;
        logic [DW-1:0] p_data;
        check("drain_start_busy", {63'd0, busy}, 64'd1);
        while (i_exp < 9 && cyc < 200) begin
            if (stalled) begin
                check("stall_addr", {60'd0, out_addr}, {60'd0, p_addr});
                check("stall_data", {32'd0, out_data}, {32'd0, p_data});
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            out_ready = rdy;
            if (inject && cyc == 0) begin
                c_valid = 1'b1; row = 2'd2; col = 2'd2; c_in = rnd_acc();
                exp_ovr = 1'b1;
            end
            check("drain_wen", {63'd0, out_wen}, 64'd1);
            if (!out_wen) break;
            if (rdy) begin
                check("drain_addr", {60'd0, out_addr}, 64'(i_exp));
                check("drain_data", {32'd0, out_data}, {32'd0, exp_q.pop_front()});
                i_exp++;
            end
            stalled = !rdy; p_addr = out_addr; p_data = out_data;
            @(posedge clk); #1;
            c_valid = 1'b0;
            cyc++;
        end
        if (i_exp < 9) check("drain_timeout", 64'(i_exp), 64'd9);
        out_ready = 1'b0;
        check("done_pulse", {63'd0, done}, 64'd1);
        check("done_wen_low", {63'd0, out_wen}, 64'd0);
        check("done_busy_low", {63'd0, busy}, 64'd0);
        if (mode == 0) check("done_latency", 64'(cyc), 64'd9);
        check("sat_flag", {63'd0, sat_flag}, {63'd0, exp_sat});
        check("overrun", {63'd0, overrun}, {63'd0, exp_ovr});
        check("incomplete", {63'd0, incomplete}, {63'd0, exp_inc});
        @(posedge clk); #1;
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("back_to_collect", {62'd0, dbg_state}, 64'd0);
        @(posedge clk); #1;
        check("no_retrigger", {62'd0, dbg_state}, 64'd0);
        check("no_retrigger_wen", {63'd0, out_wen}, 64'd0);
        mm_done = 1'b0;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wen"},   {63'd0, out_wen},    64'd0);
        check({tag, "_addr"},  {60'd0, out_addr},   64'd0);
        check({tag, "_data"},  {32'd0, out_data},   64'd0);
        check({tag, "_busy"},  {63'd0, busy},       64'd0);
        check({tag, "_done"},  {63'd0, done},       64'd0);
        check({tag, "_sat"},   {63'd0, sat_flag},   64'd0);
        check({tag, "_ovr"},   {63'd0, overrun},    64'd0);
        check({tag, "_inc"},   {63'd0, incomplete}, 64'd0);
        check({tag, "_state"}, {62'd0, dbg_state},  64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int skip;
        rst = 1'b1; c_in = '0; c_valid = 1'b0; row = 2'd0; col = 2'd0;
        mm_done = 1'b0; clr = 1'b0; out_ready = 1'b0;
        exp_sat = 0; exp_ovr = 0; exp_inc = 0;
        for (int i = 0; i < 9; i++) model_mask[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity frame: k<<16 -> k
        for (int k = 0; k < 9; k++) send(k / 3, k % 3, AW'(k) << 16);
        start_drain(0, 0, 0, '0);
        drain(0, 0);

        // Saturation both directions, then clear behaviour
        send(0, 0, AW'(1) << 48);
        send(0, 1, -(AW'(1) << 48));
        for (int k = 2; k < 9; k++) send(k / 3, k % 3, rnd_acc());
        start_drain(0, 0, 0, '0);
        drain(1, 0);
        clr = 1'b1;
        send(1, 1, AW'(1) << 50);
        clr = 1'b0;
        check("clr_vs_set", {63'd0, sat_flag}, 64'd1);
        do_clr();
        check("clr_sat", {63'd0, sat_flag}, 64'd0);

        // Rounding cases: 1.5 and -0.5 in Q16
        send(0, 0, AW'(32'h18000));
        send(0, 1, -AW'(32'h8000));
        for (int k = 2; k < 9; k++) send(k / 3, k % 3, AW'($urandom_range(0, 32'h7FFFF)));
        start_drain(0, 0, 0, '0);
        drain(2, 0);

        // Bad tags in COLLECT, then c_valid into slot 8 during DRAIN
        send(3, 1, rnd_acc());
        send(1, 3, rnd_acc());
        send_full_random();
        start_drain(0, 0, 0, '0);
        drain(0, 1);
        do_clr();
        check("clr_ovr", {63'd0, overrun}, 64'd0);

        // Slot 8 left stale: it must still hold the pre-overrun value
        for (int k = 0; k < 8; k++) send(k / 3, k % 3, rnd_acc());
        start_drain(0, 0, 0, '0);
        drain(1, 0);
        do_clr();
        check("clr_inc", {63'd0, incomplete}, 64'd0);

        // Random missing slot with random backpressure
        skip = $urandom_range(0, 8);
        for (int k = 0; k < 9; k++) if (k != skip) send(k / 3, k % 3, rnd_acc());
        start_drain(0, 0, 0, '0);
        drain(2, 0);
        do_clr();

        // Last element arrives with the mm_done edge
        for (int k = 0; k < 8; k++) send(k / 3, k % 3, rnd_acc());
        start_drain(1, 2, 2, rnd_acc());
        drain(0, 0);

        // Random frames: random order with duplicates, then fill the gaps
        for (int f = 0; f < 6; f++) begin
            for (int j = 0; j < 12; j++) send($urandom_range(0, 2), $urandom_range(0, 2), rnd_acc());
            for (int k = 0; k < 9; k++) if (!model_mask[k]) send(k / 3, k % 3, rnd_acc());
            start_drain(0, 0, 0, '0);
            drain(f % 3, 0);
        end

        // Reset in the middle of a drain
        send_full_random();
        start_drain(0, 0, 0, '0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1; mm_done = 1'b0; out_ready = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        exp_sat = 0; exp_ovr = 0; exp_inc = 0;
        for (int i = 0; i < 9; i++) model_mask[i] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_full_random();
        start_drain(0, 0, 0, '0);
        drain(2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
